// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the 16x8 RAM burst controller.
package ram_ctrl_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   // Burst length as carried on cmd_len: beats minus one.
   typedef logic [ADDR_W_DEF-1:0] beat_cnt_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst master for the single-port RAM: sequences write/read bursts from a
// command stream and owns the shared bidirectional data bus.
module ram_burst_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_adder,
   output logic              mem_we,
   inout  logic [DATA_W-1:0] mem_data
);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              rd_arm_q;

   // Output enable is the mem_we flop itself, so the bus can never be driven
   // by both sides.
   assign mem_data  = mem_we ? wr_data_q : 'z;
   assign cmd_ready = (state_q == IDLE);
   assign wd_ready  = (state_q == WR);
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         wr_data_q <= '0;
         rd_arm_q  <= 1'b0;
         mem_adder <= '0;
         mem_we    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_last   <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (rd_ready)
            rd_valid <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q   <= cmd_addr;
                  cnt_q    <= cmd_len;
                  rd_arm_q <= 1'b0;
                  if (cmd_we) begin
                     state_q <= WR;
                  end else begin
                     state_q   <= RD;
                     mem_adder <= cmd_addr;
                  end
               end
            end

            WR: begin
               if (wd_valid) begin
                  mem_we    <= 1'b1;
                  mem_adder <= addr_q;
                  wr_data_q <= wd_data;
                  addr_q    <= addr_q + 1'b1;
                  cnt_q     <= cnt_q - 1'b1;
                  if (cnt_q == '0)
                     state_q <= IDLE;
               end
            end

            RD: begin
               // First RD cycle is the bus turnaround: the RAM gets a full
               // cycle to drive the first word before it is captured.
               if (!rd_arm_q) begin
                  rd_arm_q <= 1'b1;
               end else if (!rd_valid || rd_ready) begin
                  rd_data   <= mem_data;
                  rd_valid  <= 1'b1;
                  rd_last   <= (cnt_q == '0);
                  mem_adder <= addr_q + 1'b1;
                  addr_q    <= addr_q + 1'b1;
                  cnt_q     <= cnt_q - 1'b1;
                  if (cnt_q == '0)
                     state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a behavioural 16x8 RAM on the shared bus and a
// transaction-level reference model checked every cycle.
module tb_ram_burst_ctrl;
   import ram_ctrl_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   beat_cnt_t     cmd_len;
   logic          wd_valid, wd_ready;
   logic [DW-1:0] wd_data;
   logic          rd_valid, rd_ready, rd_last, busy;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] mem_adder;
   logic          mem_we;
   wire logic [DW-1:0] mem_data;

   logic [DW-1:0] ram [16];
   logic          ram_load;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .mem_adder(mem_adder), .mem_we(mem_we), .mem_data(mem_data)
   );

   // Asynchronous-read RAM: drives the bus whenever it is not being written.
   assign mem_data = mem_we ? 'z : ram[mem_adder];

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'hF0 | 8'(i);
      end else if (mem_we) begin
         ram[mem_adder] <= mem_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   typedef struct packed { logic [7:0] d; logic l; } beat_t;

   beat_t         rdq[$];
   logic [7:0]    got[$];
   logic [3:0]    alog[$];
   logic [7:0]    ref_mem [16];
   bit            ref_init = 1'b0;
   int            wr_left = 0;
   logic [3:0]    wr_ptr = '0;
   bit            rd_act = 1'b0;
   bit            exp_we = 1'b0;
   logic [3:0]    exp_wa = '0;
   logic [7:0]    exp_wd = '0;
   bit            stall_prev = 1'b0, prev_valid = 1'b0, first_pend = 1'b0;
   logic [7:0]    hold_d = '0;
   logic          hold_l = 1'b0;
   int unsigned   cyc = 0, acc_cyc = 0;
   int            we_pulses = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      beat_t      b;
      bit         nxt_we;
      logic [3:0] a;
      if (!ref_init) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = 8'hF0 | 8'(i);
         ref_init = 1'b1;
      end
      if (!rst_n) begin
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_adder", mem_adder, 0);
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_rd_last", rd_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cmd_ready", cmd_ready, 1);
         chk("rst_wd_ready", wd_ready, 0);
         exp_we = 1'b0; wr_left = 0; rd_act = 1'b0; rdq.delete();
         stall_prev = 1'b0; prev_valid = 1'b0; first_pend = 1'b0;
      end else begin
         chk("mem_we", mem_we, exp_we);
         if (exp_we) begin
            chk("wr_adder", mem_adder, exp_wa);
            chk("wr_bus", mem_data, exp_wd);
         end
         if (mem_we) begin
            we_pulses++;
            alog.push_back(mem_adder);
         end
         chk("cmd_ready_vs_busy", cmd_ready, !busy);
         chk("wd_ready", wd_ready, wr_left > 0);
         if (!rd_act) chk("busy", busy, wr_left > 0);
         else if (!busy) rd_act = 1'b0;

         if (stall_prev) begin
            chk("stall_valid", rd_valid, 1);
            chk("stall_data", rd_data, hold_d);
            chk("stall_last", rd_last, hold_l);
         end
         if (rd_valid && !prev_valid && first_pend) begin
            chk("rd_latency", cyc - acc_cyc, 2);
            first_pend = 1'b0;
         end
         if (rd_valid && rd_ready) begin
            chk("rd_beat_expected", rdq.size() != 0, 1);
            if (rdq.size() != 0) begin
               b = rdq.pop_front();
               chk("rd_data", rd_data, b.d);
               chk("rd_last", rd_last, b.l);
               got.push_back(rd_data);
            end
         end
         stall_prev = rd_valid && !rd_ready;
         hold_d     = rd_data;
         hold_l     = rd_last;
         prev_valid = rd_valid;

         // Effects of the coming edge: pending write commits before any read
         // command accepted on that same edge looks at memory.
         if (exp_we) ref_mem[exp_wa] = exp_wd;
         nxt_we = 1'b0;
         if (wr_left > 0) begin
            if (wd_valid) begin
               nxt_we = 1'b1; exp_wa = wr_ptr; exp_wd = wd_data;
               wr_ptr = wr_ptr + 4'd1; wr_left--;
            end
         end else if (!rd_act && cmd_valid) begin
            if (cmd_we) begin
               wr_left = int'(cmd_len) + 1;
               wr_ptr  = cmd_addr;
            end else begin
               for (int i = 0; i <= int'(cmd_len); i++) begin
                  a   = cmd_addr + 4'(i);
                  b.d = ref_mem[a];
                  b.l = (i == int'(cmd_len));
                  rdq.push_back(b);
               end
               rd_act = 1'b1; first_pend = 1'b1; acc_cyc = cyc + 1;
            end
         end
         exp_we = nxt_we;
      end
   end

   // ---------------- directed stimulus ----------------
   logic [7:0] exp_q[$];

   task automatic do_cmd(input logic we, input logic [3:0] a, input logic [3:0] l);
      bit ok = 1'b0;
      int k  = 0;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
      while (!ok && k < 50) begin
         @(negedge clk); ok = cmd_ready;
         @(posedge clk); #1; k++;
      end
      cmd_valid = 1'b0;
      chk("cmd_accepted", ok, 1);
   endtask

   task automatic put_beat(input logic [7:0] d);
      bit ok = 1'b0;
      int k  = 0;
      wd_valid = 1'b1; wd_data = d;
      while (!ok && k < 50) begin
         @(negedge clk); ok = wd_ready;
         @(posedge clk); #1; k++;
      end
      wd_valid = 1'b0;
      chk("wd_accepted", ok, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string nm, input int base);
      int k = 0;
      while (got.size() < base + exp_q.size() && k < 100) begin
         @(posedge clk); k++;
      end
      #1;
      chk({nm, "_count"}, got.size(), base + exp_q.size());
      foreach (exp_q[i])
         if (base + i < got.size())
            chk($sformatf("%s_beat%0d", nm, i), got[base + i], exp_q[i]);
   endtask

   initial begin
      int gb, ab, wb, k;
      rst_n = 1'b0; ram_load = 1'b1; rd_ready = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0;
      @(posedge clk); #1 ram_load = 1'b0;
      idle(2);
      @(negedge clk);
      chk("reset_mem_we", mem_we, 0);
      chk("reset_bus_released", mem_data, 8'hF0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(1);

      // Write 4 beats at 2, read them back.
      gb = got.size();
      do_cmd(1'b1, 4'd2, 4'd3);
      put_beat(8'hA0); put_beat(8'hA1); put_beat(8'hA2); put_beat(8'hA3);
      do_cmd(1'b0, 4'd2, 4'd3);
      exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      check_got("basic", gb);

      // Wrap-around write at 14, read from 0.
      gb = got.size(); ab = alog.size();
      do_cmd(1'b1, 4'd14, 4'd3);
      put_beat(8'h11); put_beat(8'h22); put_beat(8'h33); put_beat(8'h44);
      do_cmd(1'b0, 4'd0, 4'd1);
      exp_q = '{8'h33, 8'h44};
      check_got("wrap", gb);
      exp_q = '{8'h0E, 8'h0F, 8'h00, 8'h01};
      chk("wrap_adder_count", alog.size() - ab, 4);
      foreach (exp_q[i])
         if (ab + i < alog.size())
            chk($sformatf("wrap_adder%0d", i), alog[ab + i], exp_q[i]);

      // Read with consumer stalled for 3 cycles mid-burst.
      gb = got.size();
      do_cmd(1'b0, 4'd2, 4'd3);
      k = 0;
      while (got.size() < gb + 1 && k < 50) begin @(posedge clk); k++; end
      #1 rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rd_ready = 1'b1;
      exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      check_got("bkpr", gb);

      // Write with bubbles, then immediate read-back.
      gb = got.size(); wb = we_pulses;
      do_cmd(1'b1, 4'd5, 4'd1);
      put_beat(8'h5A); idle(1); put_beat(8'hC3);
      do_cmd(1'b0, 4'd5, 4'd1);
      exp_q = '{8'h5A, 8'hC3};
      check_got("bubble", gb);
      chk("bubble_we_pulses", we_pulses - wb, 2);

      // Reset in the middle of an 8-beat write: only two beats commit.
      do_cmd(1'b1, 4'd8, 4'd7);
      put_beat(8'h80); put_beat(8'h81); put_beat(8'h82);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_mem_we", mem_we, 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      idle(1);
      gb = got.size();
      do_cmd(1'b0, 4'd8, 4'd7);
      exp_q = '{8'h80, 8'h81, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'h11, 8'h22};
      check_got("midrst", gb);

      idle(3);
      chk("rd_queue_drained", rdq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Bus master sitting directly upstream of the 16x8 single-port RAM: sole driver of its address, write-enable and shared bidirectional data bus.
- Converts a command stream (burst read or write, 1..16 beats) plus valid/ready write-data and read-data streams into correctly sequenced RAM cycles.
- Owns bus turnaround so the data bus is never driven by both sides.

Parameters:
- ADDR_W, 4, RAM address width (depth = 2**ADDR_W); also the width of cmd_len.
- DATA_W, 8, RAM word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller accepts command (high only in IDLE).
- cmd_we  in  1  1 = burst write, 0 = burst read.
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  ADDR_W  beats minus one (0 -> 1 beat, 15 -> 16 beats).
- wd_valid  in  1  write beat offered.
- wd_ready  out  1  write beat accepted (high only in WR).
- wd_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  consumer takes read beat.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  marks final beat of a read burst.
- busy  out  1  state != IDLE.
- mem_adder  out  ADDR_W  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_data  inout  DATA_W  RAM data bus; driven only while mem_we=1, otherwise high-Z.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mem_we=0, mem_adder=0, mem_data released (Z), rd_valid=0, rd_data=0, rd_last=0, busy=0, internal addr/count=0.
- States: IDLE, WR, RD.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: addr_q<=cmd_addr, cnt_q<=cmd_len. Go to WR if cmd_we=1, else go to RD with mem_adder<=cmd_addr.
- WR: wd_ready=1. Each cycle with wd_valid: mem_we<=1, mem_adder<=addr_q, bus register<=wd_data; addr_q<=addr_q+1; cnt_q<=cnt_q-1. When cnt_q==0 at acceptance, go to IDLE. A cycle without wd_valid gives mem_we<=0 (bubble); the state stays WR.
- Write timing: mem_we is high for exactly one cycle per accepted beat, the cycle after acceptance. The RAM commits on the rising edge ending that cycle. The last beat's mem_we cycle may overlap IDLE.
- RD: each cycle with (!rd_valid | rd_ready):
  - rd_data<=mem_data, rd_valid<=1, rd_last<=(cnt_q==0).
  - mem_adder<=addr_q+1, addr_q<=addr_q+1, cnt_q<=cnt_q-1.
  - When cnt_q==0, go to IDLE.
- RD stall and drain: while rd_valid & !rd_ready, rd_data, rd_last, mem_adder and cnt_q hold. rd_valid clears on rd_ready when no new beat is captured.
- Read latency: command accepted at edge T -> first rd_valid high after edge T+2. With rd_ready held high, throughput is 1 beat/cycle.
- mem_we is 0 throughout RD, and the bus is released, so the RAM drives mem_data.
- Address arithmetic is modulo 2**ADDR_W: a burst from 14 with len 3 visits 14, 15, 0, 1.
- Write-then-read: a read command accepted in the IDLE cycle where the last write's mem_we=1 is legal. Its first access happens after that write commits, so it returns the new data.
- The next command may be accepted while rd_valid is still pending from the previous burst. The RAM output is held in rd_data until consumed.
- No contention: the bus output-enable comes from the same flop as mem_we.
- Reset mid-burst: the burst is abandoned and outputs return to reset values. Beats already committed remain in the RAM, which has no reset.
- wd_valid outside WR is ignored (wd_ready=0). rd_ready without rd_valid has no effect.

Decomposition:
- Shared package ram_ctrl_pkg holds: state enum {IDLE, WR, RD}, ADDR_W/DATA_W defaults, and the beat-count type.
- No sub-module: the tri-state driver and the FSM stay in one file, about 150 lines.
- Testbench instantiates ram_burst_ctrl wired to the existing RAM block.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> mem_we=0, mem_data=Z, rd_valid=0, cmd_ready=1, busy=0.
- Write addr 2, len 3, data A0..A3 streamed, then read addr 2, len 3 with rd_ready=1 -> rd_data A0, A1, A2, A3. rd_last high only on A3. First rd_valid 2 cycles after command acceptance.
- Wrap: write addr 14, len 3, data 11, 22, 33, 44, then read addr 0, len 1 -> 33, 44. mem_adder sequence 14, 15, 0, 1.
- Backpressure: 4-beat read with rd_ready low 3 cycles mid-burst -> rd_data held stable, no beat lost or duplicated, mem_we stays 0.
- Write bubbles: wd_valid toggled 1, 0, 1, 0 over a 2-beat write -> mem_we pulses exactly twice. A read issued back-to-back returns both values.
- Reset mid-burst: assert rst_n=0 after beat 2 of an 8-beat write, then read back -> first 2 beats written, rest unchanged, FSM in IDLE.
